// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader: default
// geometry and the loader state encoding.
package imem_loader_pkg;

   localparam int DEF_ADDR_WIDTH = 6;
   localparam int DEF_NUM_WORDS  = 64;
   localparam int DEF_XLEN       = 32;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [1:0] {
      LD_IDLE  = 2'd0,
      LD_RECV  = 2'd1,
      LD_WRITE = 2'd2,
      LD_DONE  = 2'd3
   } ld_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects four stream bytes little-endian into one instruction word; the
// word output already includes the byte being accepted this cycle.
module imem_loader_byte_packer
   import imem_loader_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            clear,
   input  logic            accept,
   input  logic [7:0]      byte_data,
   output logic            word_full,
   output logic [XLEN-1:0] word
);

   logic [1:0]      byte_cnt;
   logic [XLEN-1:0] word_q;

   // Insert the incoming byte into its lane so the fourth accept yields the complete word.
   always_comb begin
      word = word_q;
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
         if (accept && (byte_cnt == 2'(k))) begin
            word[8*k +: 8] = byte_data;
         end
      end
      word_full = accept && (byte_cnt == 2'(BYTES_PER_WORD - 1));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         byte_cnt <= '0;
         word_q   <= '0;
      end else if (clear) begin
         byte_cnt <= '0;
         word_q   <= '0;
      end else if (accept) begin
         byte_cnt <= byte_cnt + 2'd1;
         word_q   <= word;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Program loader: packs a byte stream into words, writes them to instruction
// memory from address 0 and holds the core in reset until the load completes.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_WORDS  = DEF_NUM_WORDS,
   parameter int XLEN       = DEF_XLEN
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   word_count,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [XLEN-1:0]       mem_wdata,
   output logic                  cpu_reset,
   output logic                  busy,
   output logic                  done,
   output logic                  err_clamp
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] MAX_COUNT = CW'(NUM_WORDS);

   ld_state_t       state;
   logic [CW-1:0]   count;
   logic [CW-1:0]   index;
   logic            start_accept;
   logic            accept;
   logic            packer_clear;
   logic            clamp;
   logic [CW-1:0]   eff_count;
   logic            word_full;
   logic [XLEN-1:0] word;

   always_comb begin
      start_accept = start && ((state == LD_IDLE) || (state == LD_DONE));
      accept       = byte_valid && byte_ready && (state == LD_RECV);
      packer_clear = (state == LD_WRITE) || start_accept;
      clamp        = word_count > MAX_COUNT;
      eff_count    = clamp ? MAX_COUNT : word_count;
   end

   imem_loader_byte_packer #(
      .XLEN (XLEN)
   ) u_packer (
      .clock     (clock),
      .reset     (reset),
      .clear     (packer_clear),
      .accept    (accept),
      .byte_data (byte_data),
      .word_full (word_full),
      .word      (word)
   );

   // A zero-length load skips straight to DONE so the core is released without any writes.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= LD_IDLE;
         count      <= '0;
         index      <= '0;
         byte_ready <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cpu_reset  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         err_clamp  <= 1'b0;
      end else begin
         case (state)
            LD_IDLE, LD_DONE: begin
               if (start_accept) begin
                  count     <= eff_count;
                  index     <= '0;
                  err_clamp <= clamp;
                  if (eff_count == '0) begin
                     state      <= LD_DONE;
                     done       <= 1'b1;
                     cpu_reset  <= 1'b0;
                     busy       <= 1'b0;
                     byte_ready <= 1'b0;
                  end else begin
                     state      <= LD_RECV;
                     done       <= 1'b0;
                     cpu_reset  <= 1'b1;
                     busy       <= 1'b1;
                     byte_ready <= 1'b1;
                  end
               end
            end
            LD_RECV: begin
               if (word_full) begin
                  state      <= LD_WRITE;
                  byte_ready <= 1'b0;
                  mem_we     <= 1'b1;
                  mem_addr   <= index[ADDR_WIDTH-1:0];
                  mem_wdata  <= word;
               end
            end
            LD_WRITE: begin
               mem_we <= 1'b0;
               index  <= index + 1'b1;
               if (index == count - 1'b1) begin
                  state     <= LD_DONE;
                  done      <= 1'b1;
                  cpu_reset <= 1'b0;
                  busy      <= 1'b0;
               end else begin
                  state      <= LD_RECV;
                  byte_ready <= 1'b1;
               end
            end
            default: begin
               state <= LD_IDLE;
            end
         endcase
      end
   end

endmodule
